// File: rtl/clock_divider_multi_if.sv
// rtl/clock_divider_multi_if.sv - divider control/output bundle; sync member present only with CLOCK_DIV_SYNC_EN
interface clock_divider_multi_if #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS-1:0]       mode;
    logic [CHANNELS*WIDTH-1:0] scale_factor;
    logic [CHANNELS-1:0]       clk_out;
    logic [CHANNELS-1:0]       tick;
`ifdef CLOCK_DIV_SYNC_EN
    logic                      sync;

    modport master (output en, mode, scale_factor, sync, input clk_out, tick);
    modport slave  (input en, mode, scale_factor, sync, output clk_out, tick);
`else
    modport master (output en, mode, scale_factor, input clk_out, tick);
    modport slave  (input en, mode, scale_factor, output clk_out, tick);
`endif
endinterface

// File: rtl/clock_divider_multi.sv
// rtl/clock_divider_multi.sv - multi-channel shadowed clock divider; optional phase-align strobe via CLOCK_DIV_SYNC_EN
module clock_divider_multi #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    clock_divider_multi_if.slave  bus
);

    logic [WIDTH-1:0]    cnt_q [CHANNELS];
    logic [WIDTH-1:0]    cnt_d [CHANNELS];
    logic [WIDTH-1:0]    div_q [CHANNELS];
    logic [WIDTH-1:0]    div_d [CHANNELS];
    logic [CHANNELS-1:0] mode_q, mode_d;
    logic [CHANNELS-1:0] out_q, out_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic                sync_w;

`ifdef CLOCK_DIV_SYNC_EN
    assign sync_w = bus.sync;
`else
    assign sync_w = 1'b0;
`endif

    // Divisor and mode are only taken from the inputs at a wrap, so a period is never cut short.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]  = cnt_q[i];
            div_d[i]  = div_q[i];
            mode_d[i] = mode_q[i];
            out_d[i]  = mode_q[i] ? 1'b0 : out_q[i];
            tick_d[i] = 1'b0;
            if (sync_w) begin
                cnt_d[i]  = '0;
                div_d[i]  = bus.scale_factor[i*WIDTH +: WIDTH];
                mode_d[i] = bus.mode[i];
                out_d[i]  = 1'b0;
            end else if (bus.en[i]) begin
                if (cnt_q[i] >= div_q[i]) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    div_d[i]  = bus.scale_factor[i*WIDTH +: WIDTH];
                    mode_d[i] = bus.mode[i];
                    // The newly loaded mode governs the wrap edge itself.
                    out_d[i]  = bus.mode[i] ? 1'b1 : ~out_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= bus.scale_factor[i*WIDTH +: WIDTH];
            end
            mode_q <= bus.mode;
            out_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
            end
            mode_q <= mode_d;
            out_q  <= out_d;
            tick_q <= tick_d;
        end
    end

    assign bus.clk_out = out_q;
    assign bus.tick    = tick_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// tb/tb_clock_divider_multi.sv - randomized and directed bench for clock_divider_multi against a period-counting model
module tb_clock_divider_multi;
    localparam int W  = 12;
    localparam int CH = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    clock_divider_multi_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

    clock_divider_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic sync_now;
`ifdef CLOCK_DIV_SYNC_EN
    assign sync_now = bus.sync;
`else
    assign sync_now = 1'b0;
`endif

    // Reference model: each channel counts elapsed enabled cycles against a period length of N+1.
    int             m_el  [CH];
    int             m_per [CH];
    logic [CH-1:0]  m_pm;
    logic [CH-1:0]  m_out;
    logic [CH-1:0]  m_tick;

    always @(posedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (rst || sync_now) begin
                m_el[c]   <= 0;
                m_per[c]  <= int'(bus.scale_factor[c*W +: W]) + 1;
                m_pm[c]   <= bus.mode[c];
                m_out[c]  <= 1'b0;
                m_tick[c] <= 1'b0;
            end else if (bus.en[c] && (m_el[c] + 1 == m_per[c])) begin
                m_el[c]   <= 0;
                m_per[c]  <= int'(bus.scale_factor[c*W +: W]) + 1;
                m_pm[c]   <= bus.mode[c];
                m_tick[c] <= 1'b1;
                m_out[c]  <= bus.mode[c] ? 1'b1 : ~m_out[c];
            end else begin
                if (bus.en[c]) m_el[c] <= m_el[c] + 1;
                m_tick[c] <= 1'b0;
                if (m_pm[c]) m_out[c] <= 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sf(input int c, input int v);
        bus.scale_factor[c*W +: W] = W'(v);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.en           = CH'($urandom);
            bus.mode         = CH'($urandom);
            bus.scale_factor = (CH*W)'($urandom);
            cyc();
            checks++;
            if (bus.clk_out !== '0 || bus.tick !== '0) begin
                errors++;
                $display("FAIL reset k=%0d clk_out=%b tick=%b expected 00/00", k, bus.clk_out, bus.tick);
            end
        end
    endtask

    task automatic test_toggle();
        int first_rise = 0;
        int ticks = 0;
        set_sf(0, 3); set_sf(1, 0);
        bus.en = 2'b11; bus.mode = 2'b00;
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (first_rise == 0 && bus.clk_out[0]) first_rise = k;
            if (bus.tick[0]) ticks++;
            checks++;
            if (bus.clk_out[0] !== 1'(((k / 4) % 2)) || bus.clk_out[1] !== 1'(k % 2)
                || bus.tick[0] !== (k % 4 == 0)) begin
                errors++;
                $display("FAIL toggle k=%0d clk_out=%b tick=%b", k, bus.clk_out, bus.tick);
            end
            checks++;
            if (bus.clk_out !== m_out || bus.tick !== m_tick) begin
                errors++;
                $display("FAIL toggle_model k=%0d got %b/%b expected %b/%b", k, bus.clk_out, bus.tick, m_out, m_tick);
            end
        end
        checks++;
        if (first_rise != 4 || ticks != 4) begin
            errors++;
            $display("FAIL toggle_first_rise got rise=%0d ticks=%0d expected 4/4", first_rise, ticks);
        end
    endtask

    task automatic test_pulse();
        set_sf(0, 4); set_sf(1, 0);
        bus.en = 2'b01; bus.mode = 2'b01;
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 21) set_sf(0, 0);
            cyc();
            checks++;
            if (bus.clk_out[0] !== (k <= 20 ? (k % 5 == 0) : (k >= 25)) || bus.tick[0] !== bus.clk_out[0]) begin
                errors++;
                $display("FAIL pulse k=%0d clk_out=%b tick=%b", k, bus.clk_out[0], bus.tick[0]);
            end
            checks++;
            if (bus.clk_out !== m_out || bus.tick !== m_tick) begin
                errors++;
                $display("FAIL pulse_model k=%0d got %b/%b expected %b/%b", k, bus.clk_out, bus.tick, m_out, m_tick);
            end
        end
    endtask

    task automatic test_shadow();
        set_sf(0, 9);
        bus.en = 2'b01; bus.mode = 2'b00;
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            if (k == 6) set_sf(0, 2);
            cyc();
            checks++;
            if (bus.clk_out[0] !== ((k >= 10) ? (((k - 10) / 3) % 2 == 0) : 1'b0)) begin
                errors++;
                $display("FAIL shadow k=%0d clk_out=%b", k, bus.clk_out[0]);
            end
            checks++;
            if (bus.clk_out !== m_out || bus.tick !== m_tick) begin
                errors++;
                $display("FAIL shadow_model k=%0d got %b/%b expected %b/%b", k, bus.clk_out, bus.tick, m_out, m_tick);
            end
        end
    endtask

    task automatic test_enable_gating();
        int first_rise = 0;
        set_sf(0, 3);
        bus.en = 2'b01; bus.mode = 2'b00;
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            bus.en[0] = !(k >= 2 && k <= 7);
            cyc();
            if (first_rise == 0 && bus.clk_out[0]) first_rise = k;
            checks++;
            if (k <= 7 && (bus.tick[0] !== 1'b0 || bus.clk_out[0] !== 1'b0)) begin
                errors++;
                $display("FAIL gating_hold k=%0d clk_out=%b tick=%b expected 0/0", k, bus.clk_out[0], bus.tick[0]);
            end
            checks++;
            if (bus.clk_out !== m_out || bus.tick !== m_tick) begin
                errors++;
                $display("FAIL gating_model k=%0d got %b/%b expected %b/%b", k, bus.clk_out, bus.tick, m_out, m_tick);
            end
        end
        checks++;
        if (first_rise != 10) begin
            errors++;
            $display("FAIL gating_wrap got edge %0d expected 10", first_rise);
        end
    endtask

    task automatic test_reset_mid();
        set_sf(0, 15);
        bus.en = 2'b01; bus.mode = 2'b00;
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int k = 1; k <= 7; k++) cyc();
        set_sf(0, 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        checks++;
        if (bus.clk_out !== '0 || bus.tick !== '0) begin
            errors++;
            $display("FAIL reset_mid clk_out=%b tick=%b expected 00/00", bus.clk_out, bus.tick);
        end
        for (int k = 1; k <= 8; k++) begin
            cyc();
            checks++;
            if (bus.clk_out[0] !== 1'((k / 2) % 2) || bus.tick[0] !== (k % 2 == 0)) begin
                errors++;
                $display("FAIL reset_mid_period k=%0d clk_out=%b tick=%b", k, bus.clk_out[0], bus.tick[0]);
            end
        end
    endtask

    task automatic test_max_divisor();
        int first_tick = 0;
        set_sf(1, 4095);
        bus.en = 2'b10; bus.mode = 2'b10;
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int k = 1; k <= 5000 && first_tick == 0; k++) begin
            cyc();
            if (bus.tick[1]) first_tick = k;
            if (bus.clk_out !== m_out || bus.tick !== m_tick) begin
                checks++;
                errors++;
                $display("FAIL max_model k=%0d got %b/%b expected %b/%b", k, bus.clk_out, bus.tick, m_out, m_tick);
            end
        end
        checks++;
        if (first_tick != 4096) begin
            errors++;
            $display("FAIL max_divisor first tick edge %0d expected 4096", first_tick);
        end
    endtask

`ifdef CLOCK_DIV_SYNC_EN
    task automatic test_sync();
        int t0 = 0;
        int t1 = 0;
        set_sf(0, 2); set_sf(1, 5);
        bus.en = 2'b11; bus.mode = 2'b00;
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int k = 0; k < 7; k++) cyc();
        bus.sync = 1'b1; cyc(); bus.sync = 1'b0;
        checks++;
        if (bus.clk_out !== '0 || bus.tick !== '0) begin
            errors++;
            $display("FAIL sync_clear clk_out=%b tick=%b expected 00/00", bus.clk_out, bus.tick);
        end
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (t0 == 0 && bus.tick[0]) t0 = k;
            if (t1 == 0 && bus.tick[1]) t1 = k;
        end
        checks++;
        if (t0 != 3 || t1 != 6) begin
            errors++;
            $display("FAIL sync_first_ticks got %0d/%0d expected 3/6", t0, t1);
        end
        cyc(); cyc();
        set_sf(0, 0); bus.mode = 2'b01;
        rst = 1'b1; bus.sync = 1'b1; cyc(); rst = 1'b0; bus.sync = 1'b0;
        checks++;
        if (bus.clk_out !== '0 || bus.tick !== '0) begin
            errors++;
            $display("FAIL rst_sync clk_out=%b tick=%b expected 00/00", bus.clk_out, bus.tick);
        end
        cyc();
        checks++;
        if (bus.clk_out[0] !== 1'b1 || bus.clk_out !== m_out || bus.tick !== m_tick) begin
            errors++;
            $display("FAIL rst_sync_after got %b/%b expected %b/%b", bus.clk_out, bus.tick, m_out, m_tick);
        end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    int r = $urandom_range(0, 15);
                    set_sf(c, (r == 15) ? 4095 : r);
                end
                if ($urandom_range(0, 15) == 0) bus.mode[c] = ~bus.mode[c];
                bus.en[c] = ($urandom_range(0, 3) != 0);
            end
`ifdef CLOCK_DIV_SYNC_EN
            bus.sync = ($urandom_range(0, 127) == 0);
`endif
            cyc();
            checks++;
            if (bus.clk_out !== m_out || bus.tick !== m_tick) begin
                errors++;
                $display("FAIL random k=%0d got %b/%b expected %b/%b", k, bus.clk_out, bus.tick, m_out, m_tick);
            end
        end
        rst = 1'b0;
`ifdef CLOCK_DIV_SYNC_EN
        bus.sync = 1'b0;
`endif
    endtask

    initial begin
        rst              = 1'b1;
        bus.en           = '0;
        bus.mode         = '0;
        bus.scale_factor = '0;
`ifdef CLOCK_DIV_SYNC_EN
        bus.sync         = 1'b0;
`endif
        test_reset();
        test_toggle();
        test_pulse();
        test_shadow();
        test_enable_gating();
        test_reset_mid();
        test_max_divisor();
`ifdef CLOCK_DIV_SYNC_EN
        test_sync();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
